// File: rtl/boot_run_sequencer_if.sv
// Host-side program byte stream (valid/ready with a last-byte marker) feeding
// the boot/run sequencer.
interface boot_run_sequencer_if;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_last;
  logic       host_ready;

  modport master (output host_valid, output host_data, output host_last, input host_ready);
  modport slave  (input host_valid, input host_data, input host_last, output host_ready);
endinterface

// File: rtl/boot_run_sequencer.sv
// Loads a program byte stream into the core ROM, then rewinds the core and gates
// its clock for run / single-step / halt, flagging completion and watchdog expiry.
module boot_run_sequencer #(
  parameter int         ROM_DEPTH  = 256,
  parameter logic [7:0] HALT_CODE  = 8'hFF,
  parameter int         RST_CYCLES = 2,
  parameter int         CYC_W      = 16,
  parameter int         MAX_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  boot_run_sequencer_if.slave  host,
  input  logic                 cmd_run,
  input  logic                 cmd_step,
  input  logic                 cmd_halt,
  input  logic [7:0]           cpu_out,
  input  logic                 cpu_out_on,
  output logic                 rom_write,
  output logic [7:0]           rom_data,
  output logic                 core_reset,
  output logic                 core_clk_en,
  output logic [8:0]           load_count,
  output logic [CYC_W-1:0]     cycle_count,
  output logic                 done,
  output logic                 err_overflow,
  output logic                 timeout,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_PRELOAD = 3'd0,
    S_LOAD    = 3'd1,
    S_REARM   = 3'd2,
    S_HALT    = 3'd3,
    S_RUN     = 3'd4,
    S_STEP    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam int               RCW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0]   RST_LAST   = RCW'(RST_CYCLES - 1);
  localparam logic [8:0]       DEPTH_FULL = 9'(ROM_DEPTH);
  localparam bit               WD_ON      = (MAX_CYCLES != 0);
  localparam logic [CYC_W-1:0] WD_LAST    = CYC_W'(MAX_CYCLES - 1);

  state_t           state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic             rom_write_q, rom_write_d;
  logic [7:0]       rom_data_q, rom_data_d;
  logic             core_reset_q, core_reset_d;
  logic             core_clk_en_q, core_clk_en_d;
  logic [8:0]       load_count_q, load_count_d;
  logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
  logic             done_q, done_d;
  logic             err_overflow_q, err_overflow_d;
  logic             timeout_q, timeout_d;

  logic       accept;
  logic       halt_seen;
  logic       rst_done;
  logic [8:0] load_next;

  assign host.host_ready = (state_q == S_LOAD);
  assign accept          = host.host_valid && (state_q == S_LOAD);
  // The core's output strobe only means something while its clock is running.
  assign halt_seen       = core_clk_en_q && cpu_out_on && (cpu_out == HALT_CODE);
  assign rst_done        = (rst_cnt_q == RST_LAST);
  assign load_next       = load_count_q + 9'd1;

  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q + RCW'(1);
    rom_write_d    = 1'b0;
    rom_data_d     = rom_data_q;
    load_count_d   = load_count_q;
    cycle_count_d  = cycle_count_q;
    done_d         = done_q;
    err_overflow_d = err_overflow_q;
    timeout_d      = timeout_q;

    if (core_clk_en_q && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + CYC_W'(1);
    end

    unique case (state_q)
      S_PRELOAD: if (rst_done) state_d = S_LOAD;
      S_LOAD: begin
        if (accept) begin
          rom_write_d  = 1'b1;
          rom_data_d   = host.host_data;
          load_count_d = load_next;
          if (host.host_last) begin
            state_d = S_REARM;
          end else if (load_next == DEPTH_FULL) begin
            err_overflow_d = 1'b1;
            state_d        = S_REARM;
          end
        end
      end
      S_REARM: if (rst_done) state_d = S_HALT;
      S_HALT: begin
        if (host.host_valid)  state_d = S_PRELOAD;
        else if (cmd_step)    state_d = S_STEP;
        else if (cmd_run)     state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_seen) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (WD_ON && (cycle_count_q == WD_LAST)) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else if (cmd_halt) begin
          state_d = S_HALT;
        end
      end
      S_STEP: begin
        if (halt_seen) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_HALT;
        end
      end
      S_DONE: if (host.host_valid) state_d = S_PRELOAD;
      default: state_d = S_PRELOAD;
    endcase

    // Entry into any state restarts the rewind counter; only PRELOAD/REARM use it.
    if (state_d != state_q) rst_cnt_d = '0;
    if (state_d == S_PRELOAD) begin
      load_count_d   = '0;
      done_d         = 1'b0;
      err_overflow_d = 1'b0;
      timeout_d      = 1'b0;
    end
    if (state_d == S_REARM) cycle_count_d = '0;

    core_reset_d  = (state_d == S_PRELOAD) || (state_d == S_REARM);
    core_clk_en_d = (state_d == S_RUN) || (state_d == S_STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_PRELOAD;
      rst_cnt_q      <= '0;
      rom_write_q    <= 1'b0;
      rom_data_q     <= '0;
      core_reset_q   <= 1'b1;
      core_clk_en_q  <= 1'b0;
      load_count_q   <= '0;
      cycle_count_q  <= '0;
      done_q         <= 1'b0;
      err_overflow_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      rom_write_q    <= rom_write_d;
      rom_data_q     <= rom_data_d;
      core_reset_q   <= core_reset_d;
      core_clk_en_q  <= core_clk_en_d;
      load_count_q   <= load_count_d;
      cycle_count_q  <= cycle_count_d;
      done_q         <= done_d;
      err_overflow_q <= err_overflow_d;
      timeout_q      <= timeout_d;
    end
  end

  assign rom_write    = rom_write_q;
  assign rom_data     = rom_data_q;
  assign core_reset   = core_reset_q;
  assign core_clk_en  = core_clk_en_q;
  assign load_count   = load_count_q;
  assign cycle_count  = cycle_count_q;
  assign done         = done_q;
  assign err_overflow = err_overflow_q;
  assign timeout      = timeout_q;
  assign state        = state_q;

endmodule

// File: tb/tb_boot_run_sequencer.sv
// Bench for boot_run_sequencer: a watchdog-off and a MAX_CYCLES=8 instance share
// stimulus and are both tracked by a behavioural model, plus directed vectors.
module tb_boot_run_sequencer;

  localparam int CYC_SAT = 65535;
  localparam int RST_CYC = 2;
  localparam int DEPTH   = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hv = 1'b0, hl = 1'b0;
  logic [7:0] hd = 8'h00;
  logic       c_run = 1'b0, c_step = 1'b0, c_halt = 1'b0, c_on = 1'b0;
  logic [7:0] c_out = 8'h00;

  logic        rw [2];
  logic [7:0]  rd [2];
  logic        cr [2];
  logic        ce [2];
  logic [8:0]  lc [2];
  logic [15:0] cc [2];
  logic        dn [2];
  logic        ov [2];
  logic        to [2];
  logic [2:0]  st [2];
  logic        rdy [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  boot_run_sequencer_if host0 ();
  boot_run_sequencer_if host1 ();
  assign host0.host_valid = hv;
  assign host0.host_data  = hd;
  assign host0.host_last  = hl;
  assign host1.host_valid = hv;
  assign host1.host_data  = hd;
  assign host1.host_last  = hl;
  assign rdy[0] = host0.host_ready;
  assign rdy[1] = host1.host_ready;

  boot_run_sequencer dut0 (
    .clk(clk), .reset(reset), .host(host0),
    .cmd_run(c_run), .cmd_step(c_step), .cmd_halt(c_halt),
    .cpu_out(c_out), .cpu_out_on(c_on),
    .rom_write(rw[0]), .rom_data(rd[0]), .core_reset(cr[0]), .core_clk_en(ce[0]),
    .load_count(lc[0]), .cycle_count(cc[0]), .done(dn[0]), .err_overflow(ov[0]),
    .timeout(to[0]), .state(st[0])
  );

  boot_run_sequencer #(.MAX_CYCLES(8)) dut1 (
    .clk(clk), .reset(reset), .host(host1),
    .cmd_run(c_run), .cmd_step(c_step), .cmd_halt(c_halt),
    .cpu_out(c_out), .cpu_out_on(c_on),
    .rom_write(rw[1]), .rom_data(rd[1]), .core_reset(cr[1]), .core_clk_en(ce[1]),
    .load_count(lc[1]), .cycle_count(cc[1]), .done(dn[1]), .err_overflow(ov[1]),
    .timeout(to[1]), .state(st[1])
  );

  typedef struct {
    int         st;
    int         rst_left;
    int         load_cnt;
    int         cyc;
    bit         wr;
    logic [7:0] data;
    bit         done;
    bit         ovf;
    bit         to;
  } model_t;

  typedef struct {
    logic       hv;
    logic [7:0] hd;
    logic       hl;
    logic       run, step, halt, on;
    logic [7:0] cout;
    int         e_st;
    logic       e_cr, e_ce, e_rw;
    logic [7:0] e_rd;
    int         e_lc, e_cc;
    logic       e_dn, e_rdy;
  } vec_t;

  model_t m0, m1;
  vec_t   vecs [$];

  function automatic model_t modelReset();
    model_t m;
    m.st = 0; m.rst_left = RST_CYC; m.load_cnt = 0; m.cyc = 0;
    m.wr = 0; m.data = 8'h00; m.done = 0; m.ovf = 0; m.to = 0;
    return m;
  endfunction

  // One clock of the sequencer's rules, driven by the bench's current inputs.
  function automatic model_t modelNext(model_t m, int maxc);
    model_t n = m;
    bit en  = (m.st == 4) || (m.st == 5);
    bit hit = en && c_on && (c_out == 8'hFF);
    bit pre = 0;
    n.wr = 0;
    if (en) n.cyc = (m.cyc < CYC_SAT) ? m.cyc + 1 : m.cyc;
    case (m.st)
      0: begin n.rst_left = m.rst_left - 1; if (n.rst_left == 0) n.st = 1; end
      1: if (hv) begin
           n.wr = 1; n.data = hd; n.load_cnt = m.load_cnt + 1;
           if (hl || n.load_cnt == DEPTH) begin
             n.ovf = !hl; n.st = 2; n.rst_left = RST_CYC; n.cyc = 0;
           end
         end
      2: begin n.rst_left = m.rst_left - 1; if (n.rst_left == 0) n.st = 3; end
      3: if (hv) pre = 1; else if (c_step) n.st = 5; else if (c_run) n.st = 4;
      4: if (hit) begin n.done = 1; n.st = 6; end
         else if (maxc != 0 && m.cyc == maxc - 1) begin n.to = 1; n.st = 3; end
         else if (c_halt) n.st = 3;
      5: if (hit) begin n.done = 1; n.st = 6; end else n.st = 3;
      6: if (hv) pre = 1;
      default: ;
    endcase
    if (pre) begin
      n.st = 0; n.rst_left = RST_CYC; n.load_cnt = 0; n.done = 0; n.ovf = 0; n.to = 0;
    end
    return n;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic failBound(string name, int limit);
    total++;
    bad++;
    $display("[TB] FAIL %s: no progress within %0d cycles", name, limit);
  endtask

  task automatic compareOne(int i, model_t m);
    string p = (i == 0) ? "d0." : "d1.";
    checkOutput({p, "state"},        32'(st[i]),  32'(m.st));
    checkOutput({p, "host_ready"},   32'(rdy[i]), 32'(m.st == 1));
    checkOutput({p, "core_reset"},   32'(cr[i]),  32'(m.st == 0 || m.st == 2));
    checkOutput({p, "core_clk_en"},  32'(ce[i]),  32'(m.st == 4 || m.st == 5));
    checkOutput({p, "rom_write"},    32'(rw[i]),  32'(m.wr));
    checkOutput({p, "rom_data"},     32'(rd[i]),  32'(m.data));
    checkOutput({p, "load_count"},   32'(lc[i]),  32'(m.load_cnt));
    checkOutput({p, "cycle_count"},  32'(cc[i]),  32'(m.cyc));
    checkOutput({p, "done"},         32'(dn[i]),  32'(m.done));
    checkOutput({p, "err_overflow"}, 32'(ov[i]),  32'(m.ovf));
    checkOutput({p, "timeout"},      32'(to[i]),  32'(m.to));
  endtask

  task automatic tick();
    model_t n0 = modelNext(m0, 0);
    model_t n1 = modelNext(m1, 8);
    @(posedge clk);
    #1;
    m0 = n0;
    m1 = n1;
    compareOne(0, m0);
    compareOne(1, m1);
  endtask

  task automatic applyStimulus(vec_t v);
    hv = v.hv; hd = v.hd; hl = v.hl;
    c_run = v.run; c_step = v.step; c_halt = v.halt; c_on = v.on; c_out = v.cout;
  endtask

  task automatic checkVector(int r, vec_t v);
    string p = $sformatf("vec%0d.", r);
    checkOutput({p, "state"},       32'(st[0]),  32'(v.e_st));
    checkOutput({p, "core_reset"},  32'(cr[0]),  32'(v.e_cr));
    checkOutput({p, "core_clk_en"}, 32'(ce[0]),  32'(v.e_ce));
    checkOutput({p, "rom_write"},   32'(rw[0]),  32'(v.e_rw));
    checkOutput({p, "rom_data"},    32'(rd[0]),  32'(v.e_rd));
    checkOutput({p, "load_count"},  32'(lc[0]),  32'(v.e_lc));
    checkOutput({p, "cycle_count"}, 32'(cc[0]),  32'(v.e_cc));
    checkOutput({p, "done"},        32'(dn[0]),  32'(v.e_dn));
    checkOutput({p, "host_ready"},  32'(rdy[0]), 32'(v.e_rdy));
  endtask

  task automatic clearInputs();
    hv = 0; hl = 0; c_run = 0; c_step = 0; c_halt = 0; c_on = 0;
  endtask

  task automatic loadBytes(int count, bit mark_last, int base);
    int   got = 0;
    int   waited = 0;
    logic will;
    hv = 1;
    while (got < count && waited < count + 40) begin
      hd = 8'(base + got);
      hl = mark_last && (got == count - 1);
      will = rdy[0];
      tick();
      waited++;
      if (will) got++;
    end
    hv = 0;
    hl = 0;
    if (got < count) failBound("load_stream", count + 40);
  endtask

  task automatic waitState(int target, int limit, string name);
    int waited = 0;
    while (st[0] != 3'(target) && waited < limit) begin
      tick();
      waited++;
    end
    if (st[0] != 3'(target)) failBound(name, limit);
  endtask

  task automatic doReset();
    reset = 1;
    #1;
    m0 = modelReset();
    m1 = modelReset();
    compareOne(0, m0);
    compareOne(1, m1);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_watchdog: simulation did not finish");
    $fatal(1, "[TB] stuck");
  end

  initial begin
    // Columns: hv hd hl run step halt on cout | state cr ce rw rd lc cc done ready
    vecs.push_back('{0, 8'h00, 0, 0, 1, 0, 0, 8'h00,  0, 1, 0, 0, 8'h00, 0,  0, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  1, 0, 0, 0, 8'h00, 0,  0, 0, 1});
    vecs.push_back('{1, 8'h11, 0, 0, 0, 0, 0, 8'h00,  1, 0, 0, 1, 8'h11, 1,  0, 0, 1});
    vecs.push_back('{1, 8'h21, 0, 1, 0, 0, 0, 8'h00,  1, 0, 0, 1, 8'h21, 2,  0, 0, 1});
    vecs.push_back('{1, 8'hF0, 0, 0, 0, 0, 0, 8'h00,  1, 0, 0, 1, 8'hF0, 3,  0, 0, 1});
    vecs.push_back('{1, 8'h01, 0, 0, 0, 0, 0, 8'h00,  1, 0, 0, 1, 8'h01, 4,  0, 0, 1});
    vecs.push_back('{1, 8'h51, 1, 0, 0, 0, 0, 8'h00,  2, 1, 0, 1, 8'h51, 5,  0, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  2, 1, 0, 0, 8'h51, 5,  0, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  3, 0, 0, 0, 8'h51, 5,  0, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 1, 8'hFF,  3, 0, 0, 0, 8'h51, 5,  0, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 1, 0, 0, 8'h00,  5, 0, 1, 0, 8'h51, 5,  0, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  3, 0, 0, 0, 8'h51, 5,  1, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 1, 0, 0, 8'h00,  5, 0, 1, 0, 8'h51, 5,  1, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  3, 0, 0, 0, 8'h51, 5,  2, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 1, 0, 0, 8'h00,  5, 0, 1, 0, 8'h51, 5,  2, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  3, 0, 0, 0, 8'h51, 5,  3, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 1, 0, 0, 0, 8'h00,  4, 0, 1, 0, 8'h51, 5,  3, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 1, 0, 0, 0, 8'h00,  4, 0, 1, 0, 8'h51, 5,  4, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 1, 0, 0, 8'h00,  4, 0, 1, 0, 8'h51, 5,  5, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  4, 0, 1, 0, 8'h51, 5,  6, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  4, 0, 1, 0, 8'h51, 5,  7, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 1, 8'hFE,  4, 0, 1, 0, 8'h51, 5,  8, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  4, 0, 1, 0, 8'h51, 5,  9, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  4, 0, 1, 0, 8'h51, 5, 10, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  4, 0, 1, 0, 8'h51, 5, 11, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  4, 0, 1, 0, 8'h51, 5, 12, 0, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 0, 1, 8'hFF,  6, 0, 0, 0, 8'h51, 5, 13, 1, 0});
    vecs.push_back('{0, 8'h00, 0, 1, 1, 0, 0, 8'h00,  6, 0, 0, 0, 8'h51, 5, 13, 1, 0});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 1, 0, 8'h00,  6, 0, 0, 0, 8'h51, 5, 13, 1, 0});

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.state",      32'(st[0]), 32'd0);
    checkOutput("reset.core_reset", 32'(cr[0]), 32'd1);
    checkOutput("reset.rom_write",  32'(rw[0]), 32'd0);
    checkOutput("reset.host_ready", 32'(rdy[0]), 32'd0);
    reset = 0;
    m0 = modelReset();
    m1 = modelReset();
    compareOne(0, m0);
    compareOne(1, m1);

    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(vecs[r]);
      tick();
      checkVector(r, vecs[r]);
    end
    clearInputs();

    // Full ROM without a last marker.
    loadBytes(DEPTH, 1'b0, 0);
    checkOutput("ovf.state",        32'(st[0]), 32'd2);
    checkOutput("ovf.err_overflow", 32'(ov[0]), 32'd1);
    checkOutput("ovf.load_count",   32'(lc[0]), 32'd256);
    checkOutput("ovf.host_ready",   32'(rdy[0]), 32'd0);
    checkOutput("ovf.rom_data",     32'(rd[0]), 32'hFF);
    waitState(3, 10, "ovf_to_halt");
    checkOutput("ovf.sticky",       32'(ov[0]), 32'd1);

    // Watchdog instance expires after 8 enabled cycles; the other keeps running.
    c_run = 1;
    tick();
    c_run = 0;
    repeat (7) tick();
    checkOutput("wd.timeout_early", 32'(to[1]), 32'd0);
    tick();
    checkOutput("wd.timeout",       32'(to[1]), 32'd1);
    checkOutput("wd.state",         32'(st[1]), 32'd3);
    checkOutput("wd.cycle_count",   32'(cc[1]), 32'd8);
    checkOutput("wd.d0_running",    32'(st[0]), 32'd4);
    c_run = 1;
    tick();
    c_run = 0;
    c_halt = 1; c_on = 1; c_out = 8'hFF;
    tick();
    clearInputs();
    checkOutput("wd.done_wins_d0",  32'(st[0]), 32'd6);
    checkOutput("wd.done_wins_d1",  32'(st[1]), 32'd6);
    checkOutput("wd.done_flag",     32'(dn[1]), 32'd1);
    checkOutput("wd.timeout_stays", 32'(to[1]), 32'd1);

    // Asynchronous reset in the middle of a load.
    loadBytes(3, 1'b0, 8'h30);
    checkOutput("abort.pending_write", 32'(rw[0]), 32'd1);
    checkOutput("abort.load_count",    32'(lc[0]), 32'd3);
    reset = 1;
    #1;
    checkOutput("abort.core_reset", 32'(cr[0]), 32'd1);
    checkOutput("abort.rom_write",  32'(rw[0]), 32'd0);
    checkOutput("abort.state",      32'(st[0]), 32'd0);
    @(posedge clk);
    #1;
    reset = 0;
    m0 = modelReset();
    m1 = modelReset();
    loadBytes(1, 1'b0, 8'h40);
    checkOutput("reload.load_count", 32'(lc[0]), 32'd1);
    loadBytes(2, 1'b1, 8'h41);
    checkOutput("reload.rearm", 32'(st[0]), 32'd2);

    for (int c = 0; c < 4000; c++) begin
      hv     = ($urandom_range(0, 3) == 0);
      hd     = 8'($urandom);
      hl     = ($urandom_range(0, 5) == 0);
      c_run  = ($urandom_range(0, 9) == 0);
      c_step = ($urandom_range(0, 5) == 0);
      c_halt = ($urandom_range(0, 15) == 0);
      c_on   = 1'($urandom_range(0, 1));
      c_out  = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 999) == 0) doReset();
      else tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
